// File: rtl/vga_sprite_bouncer.sv
// vga_sprite_bouncer
//   Bouncing-sprite engine for the 640x480 VGA path. Sits between
//   vga_timing and a combinational sprite ROM. Once every FRAME_DIV
//   frames it moves a rectangular sprite by STEP pixels per axis,
//   reflecting off all four screen edges with exact clamping. Position
//   only changes on frame_start, which arrives in vertical blanking, so
//   a frame is never drawn with a mixed position.
//
// Ports
//   pclk        pixel clock
//   rst         synchronous, active-high reset
//   h_cnt       current column from vga_timing
//   v_cnt       current line from vga_timing
//   valid       active-video flag from vga_timing
//   frame_start one-pclk pulse at start of vertical blanking
//   pause       1 = freeze motion (fcnt, position, direction held)
//   rom_data    ROM word for rom_addr, same cycle
//   rom_addr    sprite ROM address, 0 outside the sprite
//   vga_r/g/b   registered RGB444 pixel, 1-cycle latency from h/v_cnt
//   sprite_x    current sprite left column
//   sprite_y    current sprite top line
//   bounce      one-cycle pulse after an update that flipped a direction
module vga_sprite_bouncer #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned SPR_W     = 64,
  parameter int unsigned SPR_H     = 64,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned INIT_X    = 430,
  parameter int unsigned INIT_Y    = 50,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter bit          KEY_EN    = 1'b1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              frame_start,
  input  logic              pause,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic [9:0]        sprite_x,
  output logic [9:0]        sprite_y,
  output logic              bounce
);

  localparam logic [10:0] XMAX   = 11'(H_RES - SPR_W);
  localparam logic [10:0] YMAX   = 11'(V_RES - SPR_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] SPR_WW = 11'(SPR_W);
  localparam logic [10:0] SPR_HW = 11'(SPR_H);
  localparam logic [7:0]  FDIV_M = 8'(FRAME_DIV - 1);

  typedef enum logic {
    DIR_POS,
    DIR_NEG
  } dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
    logic       flip;
  } axis_t;

  dir_t        dir_x;
  dir_t        dir_y;
  logic [7:0]  fcnt;
  logic [7:0]  fcnt_nx;
  logic        update_tick;
  axis_t       ax;
  axis_t       ay;
  logic        in_area;
  logic [9:0]  off_x;
  logic [9:0]  off_y;
  logic [21:0] lin_addr;
  logic [11:0] pix_nx;

  // One axis of motion. The sum/difference is formed in 11 bits so a step
  // past either limit is detected instead of wrapping, then clamped.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input dir_t        dir,
                                      input logic [10:0] lim);
    axis_t       r;
    logic [10:0] pw;
    pw     = {1'b0, pos};
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    if (dir == DIR_POS) begin
      if (pw + STEP_W >= lim) begin
        r.pos  = lim[9:0];
        r.dir  = DIR_NEG;
        r.flip = 1'b1;
      end else begin
        r.pos = 10'(pw + STEP_W);
      end
    end else begin
      if (pw <= STEP_W) begin
        r.pos  = '0;
        r.dir  = DIR_POS;
        r.flip = 1'b1;
      end else begin
        r.pos = 10'(pw - STEP_W);
      end
    end
    return r;
  endfunction

  // Frame divider; pause wins over a coincident frame_start.
  always_comb begin
    fcnt_nx     = fcnt;
    update_tick = 1'b0;
    if (frame_start && !pause) begin
      if (fcnt == FDIV_M) begin
        fcnt_nx     = '0;
        update_tick = 1'b1;
      end else begin
        fcnt_nx = fcnt + 8'd1;
      end
    end
  end

  always_comb begin
    ax = axis_step(sprite_x, dir_x, XMAX);
    ay = axis_step(sprite_y, dir_y, YMAX);
  end

  // Sprite hit test and position-derived ROM address.
  always_comb begin
    in_area = ({1'b0, h_cnt} >= {1'b0, sprite_x}) &&
              ({1'b0, h_cnt} <  {1'b0, sprite_x} + SPR_WW) &&
              ({1'b0, v_cnt} >= {1'b0, sprite_y}) &&
              ({1'b0, v_cnt} <  {1'b0, sprite_y} + SPR_HW);
    off_x    = h_cnt - sprite_x;
    off_y    = v_cnt - sprite_y;
    lin_addr = 22'(off_y) * 22'(SPR_W) + 22'(off_x);
    rom_addr = in_area ? lin_addr[ADDR_W-1:0] : '0;
  end

  always_comb begin
    pix_nx = '0;
    if (valid) begin
      if (!in_area) begin
        pix_nx = BG_COLOR;
      end else if (KEY_EN && (rom_data == KEY_COLOR)) begin
        pix_nx = BG_COLOR;
      end else begin
        pix_nx = rom_data;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sprite_x <= 10'(INIT_X);
      sprite_y <= 10'(INIT_Y);
      dir_x    <= DIR_POS;
      dir_y    <= DIR_NEG;
      fcnt     <= '0;
      bounce   <= 1'b0;
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
    end else begin
      fcnt   <= fcnt_nx;
      bounce <= update_tick && (ax.flip || ay.flip);
      if (update_tick) begin
        sprite_x <= ax.pos;
        dir_x    <= ax.dir;
        sprite_y <= ay.pos;
        dir_y    <= ay.dir;
      end
      {vga_r, vga_g, vga_b} <= pix_nx;
    end
  end

endmodule

// File: tb/tb_vga_sprite_bouncer.sv
// Bench for vga_sprite_bouncer: five instances with different parameter
// sets share one stimulus stream; a per-instance behavioural model
// predicts outputs every cycle, plus literal spot checks.
module tb_vga_sprite_bouncer;

  localparam int N = 5;

  logic       pclk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic       frame_start;
  logic       pause;
  bit         rom_mode;      // 1 = constant ROM word, 0 = address pattern
  logic [11:0] rom_const;

  logic [11:0] ra [N];
  logic [11:0] rd [N];
  logic [3:0]  vr [N];
  logic [3:0]  vg [N];
  logic [3:0]  vb [N];
  logic [9:0]  sx [N];
  logic [9:0]  sy [N];
  logic        bn [N];

  int p_ix [N] = '{430, 430, 574, 575, 430};
  int p_iy [N] = '{50, 50, 50, 1, 50};
  int p_st [N] = '{1, 1, 4, 1, 1};
  int p_fd [N] = '{1, 3, 1, 1, 1};
  int p_bg [N] = '{0, 0, 0, 0, 'h0A5};
  bit p_ke [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  function automatic logic [11:0] rom_fn(input logic [11:0] a, input bit m, input logic [11:0] c);
    return m ? c : (a ^ 12'h5A5);
  endfunction

  assign rd[0] = rom_fn(ra[0], rom_mode, rom_const);
  assign rd[1] = rom_fn(ra[1], rom_mode, rom_const);
  assign rd[2] = rom_fn(ra[2], rom_mode, rom_const);
  assign rd[3] = rom_fn(ra[3], rom_mode, rom_const);
  assign rd[4] = rom_fn(ra[4], rom_mode, rom_const);

  vga_sprite_bouncer u0 (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .frame_start(frame_start), .pause(pause), .rom_data(rd[0]), .rom_addr(ra[0]),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]), .sprite_x(sx[0]), .sprite_y(sy[0]),
    .bounce(bn[0]));

  vga_sprite_bouncer #(.FRAME_DIV(3)) u1 (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .frame_start(frame_start), .pause(pause), .rom_data(rd[1]), .rom_addr(ra[1]),
    .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]), .sprite_x(sx[1]), .sprite_y(sy[1]),
    .bounce(bn[1]));

  vga_sprite_bouncer #(.INIT_X(574), .STEP(4)) u2 (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .frame_start(frame_start), .pause(pause), .rom_data(rd[2]), .rom_addr(ra[2]),
    .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2]), .sprite_x(sx[2]), .sprite_y(sy[2]),
    .bounce(bn[2]));

  vga_sprite_bouncer #(.INIT_X(575), .INIT_Y(1)) u3 (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .frame_start(frame_start), .pause(pause), .rom_data(rd[3]), .rom_addr(ra[3]),
    .vga_r(vr[3]), .vga_g(vg[3]), .vga_b(vb[3]), .sprite_x(sx[3]), .sprite_y(sy[3]),
    .bounce(bn[3]));

  vga_sprite_bouncer #(.KEY_EN(1'b0), .BG_COLOR(12'h0A5)) u4 (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .frame_start(frame_start), .pause(pause), .rom_data(rd[4]), .rom_addr(ra[4]),
    .vga_r(vr[4]), .vga_g(vg[4]), .vga_b(vb[4]), .sprite_x(sx[4]), .sprite_y(sy[4]),
    .bounce(bn[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   mx [N];
  int   my [N];
  int   mdx [N];
  int   mdy [N];
  int   mf [N];
  logic [11:0] exp_rgb [N];
  bit   exp_bn [N];
  bit   seen_rst = 1'b0;

  function automatic bit inside_spr(int h, int v, int x, int y);
    return (h >= x) && (h < x + 64) && (v >= y) && (v < y + 64);
  endfunction

  function automatic int exp_addr(int h, int v, int x, int y);
    if (!inside_spr(h, v, x, y)) return 0;
    return ((v - y) * 64 + (h - x)) % 4096;
  endfunction

  function automatic logic [11:0] exp_pixel(int i, int h, int v, bit vl, int x, int y);
    logic [11:0] d;
    if (!vl) return 12'h000;
    if (!inside_spr(h, v, x, y)) return 12'(p_bg[i]);
    d = rom_fn(12'(exp_addr(h, v, x, y)), rom_mode, rom_const);
    if (p_ke[i] && d == 12'hF0F) return 12'(p_bg[i]);
    return d;
  endfunction

  // Move toward dir by step; anything reaching or passing a wall lands on it and reverses.
  function automatic void reflect(input int pos, input int dir, input int lim, input int step,
                                  output int np, output int nd, output bit fl);
    int t;
    t  = pos + dir * step;
    np = t;
    nd = dir;
    fl = 1'b0;
    if (t >= lim) begin
      np = lim; nd = -1; fl = 1'b1;
    end else if (t <= 0) begin
      np = 0; nd = 1; fl = 1'b1;
    end
  endfunction

  always @(posedge pclk) begin
    int  nx, ny, ndx, ndy;
    bit  fx, fy;
    if (rst) seen_rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mx[i] = p_ix[i]; my[i] = p_iy[i]; mdx[i] = 1; mdy[i] = -1; mf[i] = 0;
        exp_rgb[i] = 12'h000; exp_bn[i] = 1'b0;
      end else begin
        exp_rgb[i] = exp_pixel(i, int'(h_cnt), int'(v_cnt), valid, mx[i], my[i]);
        exp_bn[i]  = 1'b0;
        if (frame_start && !pause) begin
          if (mf[i] == p_fd[i] - 1) begin
            mf[i] = 0;
            reflect(mx[i], mdx[i], 576, p_st[i], nx, ndx, fx);
            reflect(my[i], mdy[i], 416, p_st[i], ny, ndy, fy);
            mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
            exp_bn[i] = fx || fy;
          end else begin
            mf[i] = mf[i] + 1;
          end
        end
      end
    end
    #1;
    if (seen_rst) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d rgb", i), 32'({vr[i], vg[i], vb[i]}), 32'(exp_rgb[i]));
        chk($sformatf("u%0d sprite_x", i), 32'(sx[i]), 32'(mx[i]));
        chk($sformatf("u%0d sprite_y", i), 32'(sy[i]), 32'(my[i]));
        chk($sformatf("u%0d bounce", i), 32'(bn[i]), 32'(exp_bn[i]));
        chk($sformatf("u%0d rom_addr", i), 32'(ra[i]),
            32'(exp_addr(int'(h_cnt), int'(v_cnt), mx[i], my[i])));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input int h, input int v, input bit vl, input bit fs);
    @(negedge pclk);
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vl; frame_start = fs;
  endtask

  task automatic settle;
    @(posedge pclk);
    #2;
  endtask

  task automatic frame_pulse;
    drive(0, 490, 1'b0, 1'b1);
    settle;
    drive(0, 491, 1'b0, 1'b0);
  endtask

  task automatic scan;
    int vl [8] = '{42, 43, 45, 49, 106, 107, 113, 114};
    for (int k = 0; k < 8; k++) begin
      for (int h = 424; h < 446; h++) drive(h, vl[k], 1'b1, 1'b0);
      for (int h = 494; h < 506; h++) drive(h, vl[k], 1'b1, 1'b0);
      for (int h = 568; h < 640; h += 3) drive(h, vl[k], 1'b1, 1'b0);
    end
    for (int v = 0; v < 4; v++)
      for (int h = 570; h < 640; h += 2) drive(h, v, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; h_cnt = '0; v_cnt = '0; valid = 1'b0; frame_start = 1'b0;
    pause = 1'b0; rom_mode = 1'b1; rom_const = 12'h123;

    drive(0, 0, 1'b0, 1'b0);
    settle;
    chk("reset u0 x", 32'(sx[0]), 32'd430);
    chk("reset u0 y", 32'(sy[0]), 32'd50);
    chk("reset u0 rgb", 32'({vr[0], vg[0], vb[0]}), 32'h000);
    chk("reset u0 bounce", 32'(bn[0]), 32'd0);
    chk("reset u3 y", 32'(sy[3]), 32'd1);
    rst = 1'b0;

    drive(430, 50, 1'b1, 1'b0);
    settle;
    chk("tl addr", 32'(ra[0]), 32'd0);
    chk("tl rgb", 32'({vr[0], vg[0], vb[0]}), 32'h123);
    drive(493, 113, 1'b1, 1'b0);
    settle;
    chk("br addr", 32'(ra[0]), 32'd4095);
    drive(494, 113, 1'b1, 1'b0);
    settle;
    chk("right of br addr", 32'(ra[0]), 32'd0);
    drive(429, 50, 1'b1, 1'b0);
    settle;
    chk("left bg u4", 32'({vr[4], vg[4], vb[4]}), 32'h0A5);
    drive(440, 60, 1'b0, 1'b0);
    settle;
    chk("blank u4", 32'({vr[4], vg[4], vb[4]}), 32'h000);
    rom_const = 12'hF0F;
    drive(440, 60, 1'b1, 1'b0);
    settle;
    chk("key u0", 32'({vr[0], vg[0], vb[0]}), 32'h000);
    chk("nokey u4", 32'({vr[4], vg[4], vb[4]}), 32'hF0F);
    rom_const = 12'h123;

    frame_pulse;
    chk("edge u2 x", 32'(sx[2]), 32'd576);
    chk("edge u2 bounce", 32'(bn[2]), 32'd1);
    chk("corner u3 x", 32'(sx[3]), 32'd576);
    chk("corner u3 y", 32'(sy[3]), 32'd0);
    chk("corner u3 bounce", 32'(bn[3]), 32'd1);
    chk("div u1 x", 32'(sx[1]), 32'd430);
    settle;
    chk("edge u2 bounce off", 32'(bn[2]), 32'd0);
    chk("corner u3 bounce off", 32'(bn[3]), 32'd0);
    frame_pulse;
    chk("edge u2 x back", 32'(sx[2]), 32'd572);
    chk("corner u3 x back", 32'(sx[3]), 32'd575);
    chk("corner u3 y back", 32'(sy[3]), 32'd1);
    chk("u3 no bounce", 32'(bn[3]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      frame_pulse;
      drive(0, 0, 1'b0, 1'b0);
    end
    settle;
    chk("div3 u1 x", 32'(sx[1]), 32'd432);
    chk("div3 u1 y", 32'(sy[1]), 32'd48);
    chk("div1 u0 x", 32'(sx[0]), 32'd436);
    chk("div1 u0 y", 32'(sy[0]), 32'd44);

    rom_mode = 1'b0;
    scan;

    pause = 1'b1;
    for (int k = 0; k < 5; k++) frame_pulse;
    settle;
    chk("pause u0 x", 32'(sx[0]), 32'd436);
    chk("pause u1 y", 32'(sy[1]), 32'd48);
    pause = 1'b0;
    frame_pulse;
    chk("resume u0 x", 32'(sx[0]), 32'd437);
    chk("resume u0 y", 32'(sy[0]), 32'd43);
    chk("fcnt held u1 x", 32'(sx[1]), 32'd432);
    scan;

    rst = 1'b1;
    drive(200, 300, 1'b1, 1'b0);
    settle;
    chk("midline rst u0 x", 32'(sx[0]), 32'd430);
    chk("midline rst u0 y", 32'(sy[0]), 32'd50);
    chk("midline rst u4 rgb", 32'({vr[4], vg[4], vb[4]}), 32'h000);
    chk("midline rst u2 x", 32'(sx[2]), 32'd574);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) drive(200 + k, 300, 1'b1, 1'b0);
    settle;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_bouncer.md
Name: vga_sprite_bouncer

Overview:
- Parametrised bouncing-sprite engine for the 640x480 VGA path.
- Sits between vga_timing (h_cnt, v_cnt, valid) and a combinational sprite ROM.
- Moves one rectangular sprite by a programmable step once every FRAME_DIV frames.
- Reflects off all four screen edges with exact clamping, optional colour-key transparency, frame-synchronous updates (no tearing), and a bounce event output.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- SPR_W, 64, sprite width in pixels
- SPR_H, 64, sprite height in lines
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- INIT_X, 430, reset x of sprite top-left; must be <= H_RES-SPR_W
- INIT_Y, 50, reset y of sprite top-left; must be <= V_RES-SPR_H
- STEP, 1, pixels moved per axis per update, 1..15
- FRAME_DIV, 1, frames per position update, 1..255
- BG_COLOR, 12'h000, background RGB444
- KEY_EN, 1, 1 = ROM pixels equal to KEY_COLOR are transparent
- KEY_COLOR, 12'hF0F, transparency key

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset
- h_cnt  in  10  current column from vga_timing
- v_cnt  in  10  current line from vga_timing
- valid  in  1  active-video flag from vga_timing
- frame_start  in  1  one-pclk pulse at start of vertical blanking
- pause  in  1  1 = freeze motion
- rom_data  in  12  ROM output for rom_addr, same cycle (combinational ROM)
- rom_addr  out  ADDR_W  sprite ROM address
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- sprite_x  out  10  current sprite left column
- sprite_y  out  10  current sprite top line
- bounce  out  1  one-cycle pulse when any direction flips

Behaviour:
- Reset: rst is synchronous and active-high; the clock is pclk.
  - Reset values: sprite_x=INIT_X, sprite_y=INIT_Y, dir_x=+, dir_y=-, frame counter=0, vga_r/g/b=0, bounce=0.
  - rst takes effect at the next pclk edge regardless of frame position.
- Limits: XMAX=H_RES-SPR_W, YMAX=V_RES-SPR_H. Positions always satisfy 0<=x<=XMAX and 0<=y<=YMAX.
- in_area is combinational: h_cnt in [x, x+SPR_W-1] and v_cnt in [y, y+SPR_H-1].
- rom_addr is combinational: (v_cnt-y)*SPR_W + (h_cnt-x), truncated to ADDR_W.
  - Outside in_area, rom_addr=0.
  - The address is position-derived, not an incrementing counter, so it needs no per-frame reset.
- Pixel output is registered, with 1-cycle latency from h_cnt/v_cnt to vga_r/g/b. Priority:
  - valid=0 -> 12'h000.
  - Else !in_area -> BG_COLOR.
  - Else KEY_EN and rom_data==KEY_COLOR -> BG_COLOR.
  - Else rom_data.
  - vga_r=[11:8], vga_g=[7:4], vga_b=[3:0].
- Frame divider:
  - On frame_start with pause=0: if fcnt==FRAME_DIV-1, then fcnt<=0 and update_tick; else fcnt<=fcnt+1.
  - pause=1 holds fcnt, position and direction. pause takes priority over a coincident frame_start.
- Position update happens only on update_tick, i.e. during blanking. Each axis is handled independently. X axis:
  - dir_x=+: if x+STEP>=XMAX, then x<=XMAX and dir_x<=-. Else x<=x+STEP.
  - dir_x=-: if x<=STEP, then x<=0 and dir_x<=+. Else x<=x-STEP.
  - The Y axis is identical using YMAX and dir_y.
  - Use 11-bit intermediates so there is no wrap-around.
- Corner: both axes flip in the same update.
- bounce=1 for exactly the cycle after an update_tick in which any direction flipped. Otherwise 0.
- sprite_x/sprite_y are registered positions, visible the cycle after update.

Test Plan:
- Reset, then one full frame with rom_data=12'h123 constant -> sprite_x=430, sprite_y=50. Pixel (430,50) outputs 12'h123 one cycle later with rom_addr=0. Pixel (493,113) gives rom_addr=4095. Pixel (429,50) gives BG_COLOR. Blanking gives 0.
- FRAME_DIV=3, STEP=1, 6 frame_start pulses -> exactly 2 updates. Position becomes (432,48).
- Right edge: force run from INIT_X=574 with STEP=4, dir + -> next update x=576 (clamped), dir_x flips, bounce pulses 1 cycle. Following update gives x=572.
- Corner: INIT_X=575, INIT_Y=1, STEP=1 -> after update x=576, y=0. Both dirs flip, single bounce pulse. Next update gives (575,1).
- Colour key: rom_data=12'hF0F inside sprite -> output BG_COLOR. KEY_EN=0 -> output 12'hF0F.
- pause=1 across 5 frame_starts -> position/fcnt unchanged. rst asserted mid-line at pixel (200,300) -> next cycle position=(430,50), rgb=0.
